// File: rtl/sme_pkg.sv
// Shared definitions for the string-matching engine host side: state encoding,
// character constants and engine port widths.
package sme_pkg;

    localparam int SME_IDX_W  = 5;
    localparam int SME_CHAR_W = 8;

    localparam logic [SME_CHAR_W-1:0] CH_SPACE  = 8'h20;
    localparam logic [SME_CHAR_W-1:0] CH_DOT    = 8'h2E;
    localparam logic [SME_CHAR_W-1:0] CH_CARET  = 8'h5E;
    localparam logic [SME_CHAR_W-1:0] CH_DOLLAR = 8'h24;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_STR = 3'd1,
        ST_SEND_PAT = 3'd2,
        ST_WAIT     = 3'd3,
        ST_RESULT   = 3'd4
    } sme_state_e;

endpackage

// File: rtl/sme_feeder_if.sv
// Host register/command/result signals plus the SME character link, as seen by
// the feeder (master) and by its environment (slave).
interface sme_feeder_if;
    import sme_pkg::*;

    logic                  wr_en;
    logic                  wr_pat;
    logic [4:0]            wr_addr;
    logic [SME_CHAR_W-1:0] wr_data;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_new_str;
    logic [5:0]            str_len;
    logic [3:0]            pat_len;

    logic [SME_CHAR_W-1:0] chardata;
    logic                  isstring;
    logic                  ispattern;
    logic                  sme_valid;
    logic                  sme_match;
    logic [SME_IDX_W-1:0]  sme_index;

    logic                  res_valid;
    logic                  res_ready;
    logic                  res_match;
    logic [SME_IDX_W-1:0]  res_index;
    logic                  res_timeout;
    logic                  res_err;
    logic                  busy;

    modport master (
        input  wr_en, wr_pat, wr_addr, wr_data,
        input  cmd_valid, cmd_new_str, str_len, pat_len,
        output cmd_ready,
        output chardata, isstring, ispattern,
        input  sme_valid, sme_match, sme_index,
        output res_valid, res_match, res_index, res_timeout, res_err, busy,
        input  res_ready
    );

    modport slave (
        output wr_en, wr_pat, wr_addr, wr_data,
        output cmd_valid, cmd_new_str, str_len, pat_len,
        input  cmd_ready,
        input  chardata, isstring, ispattern,
        output sme_valid, sme_match, sme_index,
        input  res_valid, res_match, res_index, res_timeout, res_err, busy,
        output res_ready
    );

endinterface

// File: rtl/sme_char_buf.sv
// Byte array with one write port, one asynchronous read port and a reset fill
// value; used for both the string and the pattern buffer.
module sme_char_buf
    import sme_pkg::*;
#(
    parameter int                    DEPTH = 32,
    parameter int                    AW    = 5,
    parameter logic [SME_CHAR_W-1:0] FILL  = CH_SPACE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [SME_CHAR_W-1:0] i_wdata,
    input  logic [AW-1:0]         i_raddr,
    output logic [SME_CHAR_W-1:0] o_rdata
);

    logic [SME_CHAR_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= FILL;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sme_feeder.sv
// Host-side driver for the SME: streams the buffered string and pattern to the
// engine, waits for its verdict (or a timeout) and returns it over a valid/ready port.
module sme_feeder
    import sme_pkg::*;
#(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    sme_feeder_if.master  bus
);

    localparam int STR_AW = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
    localparam int PAT_AW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;

    localparam logic [2:0] S_IDLE     = ST_IDLE;
    localparam logic [2:0] S_SEND_STR = ST_SEND_STR;
    localparam logic [2:0] S_SEND_PAT = ST_SEND_PAT;
    localparam logic [2:0] S_WAIT     = ST_WAIT;
    localparam logic [2:0] S_RESULT   = ST_RESULT;

    localparam logic [5:0] STR_MAX_V  = 6'(STR_MAX);
    localparam logic [3:0] PAT_MAX_V  = 4'(PAT_MAX);
    localparam logic [4:0] PAT_DEPTH5 = 5'(PAT_MAX);
    localparam logic [6:0] WAIT_LAST  = 7'(TIMEOUT - 1);

    logic [2:0]            r_state;
    logic [5:0]            r_idx;
    logic [5:0]            r_str_len;
    logic [3:0]            r_pat_len;
    logic [6:0]            r_wait_cnt;
    logic                  r_cmd_ready;
    logic                  r_busy;
    logic [SME_CHAR_W-1:0] r_chardata;
    logic                  r_isstring;
    logic                  r_ispattern;
    logic                  r_res_valid;
    logic                  r_res_match;
    logic [SME_IDX_W-1:0]  r_res_index;
    logic                  r_res_timeout;
    logic                  r_res_err;

    logic                  w_idle;
    logic                  w_cmd_fire;
    logic                  w_cmd_bad;
    logic                  w_str_we;
    logic                  w_pat_we;
    logic [STR_AW-1:0]     w_str_raddr;
    logic [PAT_AW-1:0]     w_pat_raddr;
    logic [SME_CHAR_W-1:0] w_str_rdata;
    logic [SME_CHAR_W-1:0] w_pat_rdata;
    logic [5:0]            w_pat_len6;
    logic [6:0]            w_wait_next;

    assign w_idle     = (r_state == S_IDLE);
    assign w_cmd_fire = w_idle && r_cmd_ready && bus.cmd_valid;
    assign w_cmd_bad  = (bus.pat_len == 4'd0) || (bus.pat_len > PAT_MAX_V) ||
                        (bus.cmd_new_str && ((bus.str_len == 6'd0) || (bus.str_len > STR_MAX_V)));

    // Out-of-range addresses are dropped, never wrapped into the buffer.
    assign w_str_we = bus.wr_en && w_idle && !bus.wr_pat && ({1'b0, bus.wr_addr} < STR_MAX_V);
    assign w_pat_we = bus.wr_en && w_idle &&  bus.wr_pat && (bus.wr_addr < PAT_DEPTH5);

    // Outside its own send phase each buffer presents char 0, ready for the phase's first beat.
    assign w_str_raddr = (r_state == S_SEND_STR) ? r_idx[STR_AW-1:0] : '0;
    assign w_pat_raddr = (r_state == S_SEND_PAT) ? r_idx[PAT_AW-1:0] : '0;
    assign w_pat_len6  = {2'b00, r_pat_len};
    assign w_wait_next = (r_wait_cnt == 7'h7F) ? r_wait_cnt : r_wait_cnt + 7'd1;

    sme_char_buf #(.DEPTH(STR_MAX), .AW(STR_AW), .FILL(CH_SPACE)) u_str_buf (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_str_we),
        .i_waddr (bus.wr_addr[STR_AW-1:0]),
        .i_wdata (bus.wr_data),
        .i_raddr (w_str_raddr),
        .o_rdata (w_str_rdata)
    );

    sme_char_buf #(.DEPTH(PAT_MAX), .AW(PAT_AW), .FILL(CH_DOT)) u_pat_buf (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_pat_we),
        .i_waddr (bus.wr_addr[PAT_AW-1:0]),
        .i_wdata (bus.wr_data),
        .i_raddr (w_pat_raddr),
        .o_rdata (w_pat_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_str_len     <= '0;
            r_pat_len     <= '0;
            r_wait_cnt    <= '0;
            r_cmd_ready   <= 1'b0;
            r_busy        <= 1'b0;
            r_chardata    <= '0;
            r_isstring    <= 1'b0;
            r_ispattern   <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_match   <= 1'b0;
            r_res_index   <= '0;
            r_res_timeout <= 1'b0;
            r_res_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_str_len   <= bus.str_len;
                        r_pat_len   <= bus.pat_len;
                        r_idx       <= 6'd1;
                        if (w_cmd_bad) begin
                            r_state       <= S_RESULT;
                            r_res_valid   <= 1'b1;
                            r_res_err     <= 1'b1;
                            r_res_match   <= 1'b0;
                            r_res_index   <= '0;
                            r_res_timeout <= 1'b0;
                        end else if (bus.cmd_new_str) begin
                            r_state    <= S_SEND_STR;
                            r_isstring <= 1'b1;
                            r_chardata <= w_str_rdata;
                        end else begin
                            r_state     <= S_SEND_PAT;
                            r_ispattern <= 1'b1;
                            r_chardata  <= w_pat_rdata;
                        end
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                S_SEND_STR: begin
                    if (r_idx < r_str_len) begin
                        r_chardata <= w_str_rdata;
                        r_idx      <= r_idx + 6'd1;
                    end else begin
                        r_state     <= S_SEND_PAT;
                        r_isstring  <= 1'b0;
                        r_ispattern <= 1'b1;
                        r_chardata  <= w_pat_rdata;
                        r_idx       <= 6'd1;
                    end
                end
                S_SEND_PAT: begin
                    if (r_idx < w_pat_len6) begin
                        r_chardata <= w_pat_rdata;
                        r_idx      <= r_idx + 6'd1;
                    end else begin
                        r_state     <= S_WAIT;
                        r_ispattern <= 1'b0;
                        r_chardata  <= '0;
                        r_wait_cnt  <= '0;
                    end
                end
                S_WAIT: begin
                    r_wait_cnt <= w_wait_next;
                    // A verdict arriving on the timeout cycle takes priority.
                    if (bus.sme_valid) begin
                        r_state       <= S_RESULT;
                        r_res_valid   <= 1'b1;
                        r_res_match   <= bus.sme_match;
                        r_res_index   <= bus.sme_index;
                        r_res_timeout <= 1'b0;
                        r_res_err     <= 1'b0;
                    end else if (r_wait_cnt >= WAIT_LAST) begin
                        r_state       <= S_RESULT;
                        r_res_valid   <= 1'b1;
                        r_res_match   <= 1'b0;
                        r_res_index   <= '0;
                        r_res_timeout <= 1'b1;
                        r_res_err     <= 1'b0;
                    end
                end
                S_RESULT: begin
                    if (bus.res_ready) begin
                        r_state       <= S_IDLE;
                        r_busy        <= 1'b0;
                        r_cmd_ready   <= 1'b1;
                        r_res_valid   <= 1'b0;
                        r_res_match   <= 1'b0;
                        r_res_index   <= '0;
                        r_res_timeout <= 1'b0;
                        r_res_err     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.busy        = r_busy;
    assign bus.chardata    = r_chardata;
    assign bus.isstring    = r_isstring;
    assign bus.ispattern   = r_ispattern;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_match   = r_res_match;
    assign bus.res_index   = r_res_index;
    assign bus.res_timeout = r_res_timeout;
    assign bus.res_err     = r_res_err;

endmodule

// File: tb/tb_sme_feeder.sv
// Scoreboard bench for sme_feeder: stimulus queues expected SME beats and results,
// independent monitors pop and compare them; a small SME model answers commands.
module tb_sme_feeder;
    import sme_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sme_feeder_if sif ();

    logic       mdl_valid, mdl_match, stray_valid;
    logic [4:0] mdl_index;
    assign sif.sme_valid = mdl_valid | stray_valid;
    assign sif.sme_match = mdl_match;
    assign sif.sme_index = mdl_index;

    sme_feeder #(.STR_MAX(32), .PAT_MAX(8), .TIMEOUT(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    typedef struct packed {logic s; logic p; logic [7:0] c; logic last;} chr_t;
    typedef struct {logic [7:0] v; int lat;} res_t;

    chr_t exp_chr[$];
    res_t exp_res[$];
    logic [7:0] str_mdl [32];
    logic [7:0] pat_mdl [8];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_chars = 0;
    int last_act_cyc = 0;

    logic       sme_en = 1'b0;
    int         sme_delay = 2;
    logic       sme_m = 1'b0;
    logic [4:0] sme_i = 5'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rvec(input logic m, input logic [4:0] idx, input logic to, input logic err);
        return {m, idx, to, err};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) str_mdl[i] = 8'h20;
        for (int i = 0; i < 8; i++)  pat_mdl[i] = 8'h2E;
    endtask

    // Character stream monitor
    initial begin : mon_stream
        logic prev_act, prev_last, act;
        chr_t e;
        prev_act = 1'b0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_act = 1'b0;
                prev_last = 1'b0;
            end else begin
                act = sif.isstring | sif.ispattern;
                if (act) begin
                    n_chars++;
                    last_act_cyc = cyc;
                    if (exp_chr.size() == 0) begin
                        check("stream_extra", 32'(act), 32'(0));
                        prev_last = 1'b1;
                    end else begin
                        e = exp_chr.pop_front();
                        check("stream_char", 32'({sif.isstring, sif.ispattern, sif.chardata}),
                              32'({e.s, e.p, e.c}));
                        prev_last = e.last;
                    end
                end else if (prev_act) begin
                    check("stream_gap", 32'(prev_last), 32'(1));
                    check("idle_chardata", 32'(sif.chardata), 32'(0));
                end
                prev_act = act;
            end
        end
    end

    // Result port monitor
    initial begin : mon_res
        logic prev_v;
        logic [7:0] rv;
        res_t h;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_v = 1'b0;
            end else begin
                if (sif.res_valid) begin
                    rv = {sif.res_match, sif.res_index, sif.res_timeout, sif.res_err};
                    check("cmd_ready_in_result", 32'(sif.cmd_ready), 32'(0));
                    if (exp_res.size() == 0) begin
                        if (!prev_v) check("res_extra", 32'(sif.res_valid), 32'(0));
                    end else begin
                        h = exp_res[0];
                        if (!prev_v && h.lat != 0)
                            check("res_latency", 32'(cyc - last_act_cyc), 32'(h.lat));
                        if (sif.res_ready) begin
                            void'(exp_res.pop_front());
                            check("result", 32'(rv), 32'(h.v));
                        end else begin
                            check("res_hold", 32'(rv), 32'(h.v));
                        end
                    end
                end
                prev_v = sif.res_valid;
            end
        end
    end

    // SME model: answers sme_delay edges after the last pattern beat
    initial begin : sme_model
        logic prev_p, fire;
        prev_p = 1'b0;
        mdl_valid = 1'b0;
        mdl_match = 1'b0;
        mdl_index = 5'd0;
        forever begin
            @(negedge clk);
            fire = !reset && prev_p && !sif.ispattern && sme_en;
            prev_p = reset ? 1'b0 : sif.ispattern;
            if (fire) begin
                if (sme_delay > 1) repeat (sme_delay - 1) @(posedge clk);
                #1;
                mdl_valid = 1'b1;
                mdl_match = sme_m;
                mdl_index = sme_i;
                @(posedge clk);
                #1;
                mdl_valid = 1'b0;
                mdl_match = 1'b0;
                mdl_index = 5'd0;
            end
        end
    end

    initial begin : watchdog
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got no end of test, required end within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic wr(input logic pat, input int addr, input logic [7:0] d, input logic ok);
        @(posedge clk); #1;
        sif.wr_en = 1'b1;
        sif.wr_pat = pat;
        sif.wr_addr = 5'(addr);
        sif.wr_data = d;
        @(posedge clk); #1;
        sif.wr_en = 1'b0;
        if (ok) begin
            if (pat && addr < 8) pat_mdl[addr] = d;
            else if (!pat && addr < 32) str_mdl[addr] = d;
        end
    endtask

    task automatic wr_s(input logic pat, input string s);
        for (int i = 0; i < s.len(); i++) wr(pat, i, s[i], 1'b1);
    endtask

    task automatic cmd(input logic ns, input int L, input int P, input logic bad,
                       input logic [7:0] rv, input int lat);
        logic acc, rdy;
        chr_t e;
        if (!bad) begin
            if (ns) for (int i = 0; i < L; i++) begin
                e = '{s: 1'b1, p: 1'b0, c: str_mdl[i], last: 1'b0};
                exp_chr.push_back(e);
            end
            for (int i = 0; i < P; i++) begin
                e = '{s: 1'b0, p: 1'b1, c: pat_mdl[i], last: (i == P - 1)};
                exp_chr.push_back(e);
            end
        end
        exp_res.push_back('{v: rv, lat: lat});
        @(posedge clk); #1;
        sif.cmd_valid = 1'b1;
        sif.cmd_new_str = ns;
        sif.str_len = 6'(L);
        sif.pat_len = 4'(P);
        acc = 1'b0;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            rdy = sif.cmd_ready;
            @(posedge clk);
            acc = rdy;
        end
        #1;
        sif.cmd_valid = 1'b0;
        if (!acc) begin
            check("cmd_accept", 32'(acc), 32'(1));
        end else begin
            @(negedge clk);
            if (bad)
                check("err_next_cycle", 32'({sif.res_valid, sif.res_err, sif.isstring, sif.ispattern}),
                      32'(4'b1100));
            else
                check("first_beat_cycle", 32'({sif.isstring, sif.ispattern}), 32'({ns, !ns}));
        end
    endtask

    task automatic wait_done(input int max);
        int k;
        k = 0;
        while (exp_res.size() != 0 && k < max) begin
            @(negedge clk);
            k++;
        end
        if (exp_res.size() != 0) begin
            check("result_wait", 32'(exp_res.size()), 32'(0));
            exp_res.delete();
            exp_chr.delete();
        end
        @(negedge clk);
    endtask

    initial begin : stim
        int base, k;
        sif.wr_en = 1'b0; sif.wr_pat = 1'b0; sif.wr_addr = '0; sif.wr_data = '0;
        sif.cmd_valid = 1'b0; sif.cmd_new_str = 1'b0; sif.str_len = '0; sif.pat_len = '0;
        sif.res_ready = 1'b1;
        stray_valid = 1'b0;
        model_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cmd_ready", 32'(sif.cmd_ready), 32'(0));
        check("reset_outputs", 32'({sif.isstring, sif.ispattern, sif.chardata, sif.res_valid,
              sif.res_match, sif.res_index, sif.res_timeout, sif.res_err, sif.busy}), 32'(0));
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_reset_cmd_ready", 32'(sif.cmd_ready), 32'(1));
        check("post_reset_busy", 32'(sif.busy), 32'(0));

        // "hello world" / "wor", with a dropped out-of-range pattern write
        wr_s(1'b0, "hello world");
        wr_s(1'b1, "wor");
        wr(1'b1, 9, 8'h5A, 1'b0);
        sme_en = 1'b1; sme_delay = 2; sme_m = 1'b1; sme_i = 5'd6;
        cmd(1'b1, 11, 3, 1'b0, rvec(1'b1, 5'd6, 1'b0, 1'b0), 3);
        wait_done(200);

        // pattern-only "^hel", str_len 0 irrelevant
        wr_s(1'b1, "^hel");
        sme_m = 1'b1; sme_i = 5'd0;
        cmd(1'b0, 0, 4, 1'b0, rvec(1'b1, 5'd0, 1'b0, 1'b0), 3);
        wait_done(200);

        // sme_valid while IDLE must be ignored
        @(posedge clk); #1 stray_valid = 1'b1;
        @(posedge clk); #1 stray_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("stray_sme_valid", 32'(sif.res_valid), 32'(0));

        // silent SME -> timeout
        sme_en = 1'b0;
        cmd(1'b1, 5, 2, 1'b0, rvec(1'b0, 5'd0, 1'b1, 1'b0), 65);
        wait_done(200);

        // verdict on the timeout cycle wins
        sme_en = 1'b1; sme_delay = 64; sme_m = 1'b1; sme_i = 5'd17;
        cmd(1'b0, 0, 3, 1'b0, rvec(1'b1, 5'd17, 1'b0, 1'b0), 65);
        wait_done(200);

        // maximum lengths, earliest verdict
        sme_delay = 1; sme_m = 1'b0; sme_i = 5'd0;
        cmd(1'b1, 32, 8, 1'b0, rvec(1'b0, 5'd0, 1'b0, 1'b0), 2);
        wait_done(200);

        // illegal lengths
        cmd(1'b1, 11, 0, 1'b1, rvec(1'b0, 5'd0, 1'b0, 1'b1), 0);
        wait_done(50);
        cmd(1'b1, 33, 3, 1'b1, rvec(1'b0, 5'd0, 1'b0, 1'b1), 0);
        wait_done(50);
        cmd(1'b0, 5, 9, 1'b1, rvec(1'b0, 5'd0, 1'b0, 1'b1), 0);
        wait_done(50);
        cmd(1'b1, 0, 3, 1'b1, rvec(1'b0, 5'd0, 1'b0, 1'b1), 0);
        wait_done(50);

        // host stalls the result; writes meanwhile are dropped
        sif.res_ready = 1'b0;
        sme_delay = 2; sme_m = 1'b1; sme_i = 5'd3;
        cmd(1'b0, 0, 2, 1'b0, rvec(1'b1, 5'd3, 1'b0, 1'b0), 3);
        k = 0;
        while (!sif.res_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("hold_res_valid_seen", 32'(sif.res_valid), 32'(1));
        for (int i = 0; i < 5; i++) wr(1'b0, i, 8'h4A, 1'b0);
        @(negedge clk);
        check("hold_busy", 32'(sif.busy), 32'(1));
        @(posedge clk); #1 sif.res_ready = 1'b1;
        wait_done(50);
        cmd(1'b1, 3, 1, 1'b0, rvec(1'b1, 5'd3, 1'b0, 1'b0), 3);
        wait_done(200);

        // reset on the third string beat
        sme_en = 1'b0;
        base = n_chars;
        cmd(1'b1, 11, 3, 1'b0, rvec(1'b0, 5'd0, 1'b1, 1'b0), 0);
        k = 0;
        while (n_chars < base + 3 && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        check("third_beat_seen", 32'(n_chars - base), 32'(3));
        reset = 1'b1;
        #1;
        check("midreset_outputs", 32'({sif.isstring, sif.ispattern, sif.chardata, sif.res_valid,
              sif.cmd_ready, sif.busy}), 32'(0));
        exp_chr.delete();
        exp_res.delete();
        model_reset();
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midreset_cmd_ready", 32'(sif.cmd_ready), 32'(1));
        sme_en = 1'b1; sme_delay = 2; sme_m = 1'b0; sme_i = 5'd0;
        cmd(1'b1, 3, 8, 1'b0, rvec(1'b0, 5'd0, 1'b0, 1'b0), 3);
        wait_done(200);
        check("leftover_beats", 32'(exp_chr.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
